// File: rtl/alu_issue_ctrl.sv
// alu_issue_ctrl: issue/writeback controller wrapped around an external
// combinational 4-bit ALU. Each instruction is accepted in IDLE. Its operands
// are read from a 4x4 register file and registered onto the ALU inputs. The
// ALU result, or a load immediate, is written back in EXEC. The result is then
// offered on a valid/ready output stream in OUT.
module alu_issue_ctrl #(
    parameter int OPCNT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [9:0]         in_instr,
    output logic [3:0]         alu_a,
    output logic [3:0]         alu_b,
    output logic [2:0]         alu_ctrl,
    input  logic [3:0]         alu_result,
    input  logic               alu_carry,
    input  logic               alu_zero,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [3:0]         out_result,
    output logic               out_carry,
    output logic               out_zero,
    output logic [1:0]         out_rd,
    output logic [OPCNT_W-1:0] op_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        OUT  = 2'd2
    } state_t;

    state_t state_reg, state_next;

    // Instruction fields: {ld, op[2:0], rd[1:0], rs1[1:0], rs2[1:0]}
    logic       in_ld;
    logic [2:0] in_op;
    logic [1:0] in_rd;
    logic [1:0] in_rs1;
    logic [1:0] in_rs2;

    assign in_ld  = in_instr[9];
    assign in_op  = in_instr[8:6];
    assign in_rd  = in_instr[5:4];
    assign in_rs1 = in_instr[3:2];
    assign in_rs2 = in_instr[1:0];

    // Latched instruction state carried from IDLE into EXEC.
    logic       ld_reg;
    logic [1:0] rd_reg;
    logic [3:0] imm_reg;

    // Architectural state and output registers.
    logic [3:0]         rf_reg [4];
    logic [3:0]         alu_a_reg, alu_b_reg;
    logic [2:0]         alu_ctrl_reg;
    logic               out_valid_reg, out_carry_reg, out_zero_reg;
    logic [3:0]         out_result_reg;
    logic [1:0]         out_rd_reg;
    logic [OPCNT_W-1:0] op_count_reg;

    logic       accept;
    logic [3:0] wb_value;
    logic       wb_carry;
    logic       wb_zero;
    logic [3:0] rf_we;

    assign in_ready = (state_reg == IDLE);
    assign accept   = in_valid && (state_reg == IDLE);

    // A load bypasses the ALU completely: its value is the 4-bit immediate {rs1, rs2}.
    assign wb_value = ld_reg ? imm_reg : alu_result;
    assign wb_carry = ld_reg ? 1'b0 : alu_carry;
    assign wb_zero  = ld_reg ? (imm_reg == 4'd0) : alu_zero;

    // One write enable per register-file entry. Writeback happens only in EXEC.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_rf_we
            assign rf_we[gi] = (state_reg == EXEC) && (rd_reg == 2'(gi));
        end
    endgenerate

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    // Next-state logic. EXEC always lasts exactly one cycle.
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = EXEC;
            EXEC:    state_next = OUT;
            OUT:     if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Register file writeback. A reset part-way through an instruction
    // clears the entries before any writeback can happen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 4; i++) rf_reg[i] <= 4'd0;
        end else begin
            for (int i = 0; i < 4; i++)
                if (rf_we[i]) rf_reg[i] <= wb_value;
        end
    end

    // Operand issue at accept. The ALU inputs hold their values until the next accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_a_reg    <= 4'd0;
            alu_b_reg    <= 4'd0;
            alu_ctrl_reg <= 3'd0;
            ld_reg       <= 1'b0;
            rd_reg       <= 2'd0;
            imm_reg      <= 4'd0;
        end else if (accept) begin
            alu_a_reg    <= rf_reg[in_rs1];
            alu_b_reg    <= rf_reg[in_rs2];
            alu_ctrl_reg <= in_op;
            ld_reg       <= in_ld;
            rd_reg       <= in_rd;
            imm_reg      <= {in_rs1, in_rs2};
        end
    end

    // Result capture in EXEC, output handshake in OUT, and the completed-op counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_reg  <= 1'b0;
            out_result_reg <= 4'd0;
            out_carry_reg  <= 1'b0;
            out_zero_reg   <= 1'b0;
            out_rd_reg     <= 2'd0;
            op_count_reg   <= '0;
        end else begin
            if (state_reg == EXEC) begin
                out_result_reg <= wb_value;
                out_carry_reg  <= wb_carry;
                out_zero_reg   <= wb_zero;
                out_rd_reg     <= rd_reg;
                out_valid_reg  <= 1'b1;
            end else if ((state_reg == OUT) && out_ready) begin
                out_valid_reg <= 1'b0;
                op_count_reg  <= op_count_reg + 1'b1;
            end
        end
    end

    assign alu_a      = alu_a_reg;
    assign alu_b      = alu_b_reg;
    assign alu_ctrl   = alu_ctrl_reg;
    assign out_valid  = out_valid_reg;
    assign out_result = out_result_reg;
    assign out_carry  = out_carry_reg;
    assign out_zero   = out_zero_reg;
    assign out_rd     = out_rd_reg;
    assign op_count   = op_count_reg;

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Directed testbench for alu_issue_ctrl. A behavioural 4-bit ALU model closes
// the loop around each DUT. A second instance with a 2-bit counter shares the
// same stimulus so that counter wrap can be observed.
// ALU encoding used by the model:
//   000 add, 001 sub (carry = borrow), 010 and, 011 or,
//   100 xor, 101 nor, 110 shl (carry = a[3]), 111 shr (carry = a[0]).
`timescale 1ns/1ps
module tb_alu_issue_ctrl;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic [9:0] in_instr = '0;
    logic       out_ready = 1'b0;

    logic       in_ready, out_valid, out_carry, out_zero;
    logic [3:0] alu_a, alu_b, alu_result, out_result;
    logic [2:0] alu_ctrl;
    logic       alu_carry, alu_zero;
    logic [1:0] out_rd;
    logic [7:0] op_count;

    logic       w_in_ready, w_out_valid, w_out_carry, w_out_zero;
    logic [3:0] w_alu_a, w_alu_b, w_alu_result, w_out_result;
    logic [2:0] w_alu_ctrl;
    logic       w_alu_carry, w_alu_zero;
    logic [1:0] w_out_rd;
    logic [1:0] w_op_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    // Reference ALU: returns {carry, result}.
    function automatic logic [4:0] alu_f(input logic [3:0] a, input logic [3:0] b, input logic [2:0] c);
        logic [4:0] r;
        case (c)
            3'b000:  r = {1'b0, a} + {1'b0, b};
            3'b001:  r = {(a < b), 4'(a - b)};
            3'b010:  r = {1'b0, a & b};
            3'b011:  r = {1'b0, a | b};
            3'b100:  r = {1'b0, a ^ b};
            3'b101:  r = {1'b0, ~(a | b)};
            3'b110:  r = {a[3], a[2:0], 1'b0};
            default: r = {a[0], 1'b0, a[3:1]};
        endcase
        return r;
    endfunction

    always_comb begin
        {alu_carry, alu_result} = alu_f(alu_a, alu_b, alu_ctrl);
        alu_zero = (alu_result == 4'd0);
        {w_alu_carry, w_alu_result} = alu_f(w_alu_a, w_alu_b, w_alu_ctrl);
        w_alu_zero = (w_alu_result == 4'd0);
    end

    alu_issue_ctrl #(.OPCNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .alu_a(alu_a), .alu_b(alu_b), .alu_ctrl(alu_ctrl),
        .alu_result(alu_result), .alu_carry(alu_carry), .alu_zero(alu_zero),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_carry(out_carry), .out_zero(out_zero), .out_rd(out_rd), .op_count(op_count)
    );

    alu_issue_ctrl #(.OPCNT_W(2)) dut_w (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(w_in_ready),
        .in_instr(in_instr), .alu_a(w_alu_a), .alu_b(w_alu_b), .alu_ctrl(w_alu_ctrl),
        .alu_result(w_alu_result), .alu_carry(w_alu_carry), .alu_zero(w_alu_zero),
        .out_valid(w_out_valid), .out_ready(out_ready), .out_result(w_out_result),
        .out_carry(w_out_carry), .out_zero(w_out_zero), .out_rd(w_out_rd), .op_count(w_op_count)
    );

    function automatic logic [9:0] mk(input logic ld, input logic [2:0] op, input logic [1:0] rd,
                                      input logic [1:0] rs1, input logic [1:0] rs2);
        return {ld, op, rd, rs1, rs2};
    endfunction

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Sends one instruction and waits up to 8 cycles for the result, then completes
    // the output handshake. Returns the ALU inputs seen in EXEC, the result fields
    // and the number of edges after the accept edge (99 if the result never came).
    task automatic exec_op(input logic [9:0] instr, output logic [3:0] res, output logic c,
                           output logic z, output logic [1:0] rd, output logic [3:0] a,
                           output logic [3:0] b, output logic [2:0] ctl, output int lat);
        @(negedge clk);
        in_instr = instr;
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        a = alu_a;
        b = alu_b;
        ctl = alu_ctrl;
        lat = 0;
        while (!out_valid && lat < 8) begin
            @(posedge clk);
            #1;
            lat++;
        end
        if (!out_valid) lat = 99;
        res = out_result;
        c = out_carry;
        z = out_zero;
        rd = out_rd;
        $display("op instr=%b a=%b b=%b ctl=%b -> result=%b carry=%b zero=%b rd=%0d lat=%0d",
                 instr, a, b, ctl, res, c, z, rd, lat);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    logic [3:0] r_res, r_a, r_b;
    logic       r_c, r_z;
    logic [1:0] r_rd;
    logic [2:0] r_ctl;
    int         r_lat;

    task automatic test_reset();
        logic ov_after_n;
        rst_n = 1'b0;
        #12;
        n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        n_checks++; if ({out_result, out_carry, out_zero, out_rd} !== 8'd0) begin n_fail++;
            $display("FAIL reset_out_fields: got %b want 0", {out_result, out_carry, out_zero, out_rd}); end
        n_checks++; if ({alu_a, alu_b, alu_ctrl} !== 11'd0) begin n_fail++;
            $display("FAIL reset_alu_inputs: got %b want 0", {alu_a, alu_b, alu_ctrl}); end
        n_checks++; if (op_count !== 8'd0) begin n_fail++; $display("FAIL reset_op_count: got %0d want 0", op_count); end
        @(negedge clk);
        rst_n = 1'b1;
        // ld r1 = 0011, with explicit latency checks on out_valid.
        @(negedge clk);
        in_instr = mk(1'b1, 3'b000, 2'd1, 2'b00, 2'b11);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        ov_after_n = out_valid;
        @(posedge clk);
        #1;
        n_checks++; if (ov_after_n !== 1'b0) begin n_fail++; $display("FAIL ld_valid_early: got %b want 0 after accept edge", ov_after_n); end
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL ld_valid_late: got %b want 1 one edge after accept", out_valid); end
        n_checks++; if (out_result !== 4'b0011) begin n_fail++; $display("FAIL ld_result: got %b want 0011", out_result); end
        n_checks++; if ({out_carry, out_zero} !== 2'b00) begin n_fail++; $display("FAIL ld_flags: got %b want 00", {out_carry, out_zero}); end
        n_checks++; if (out_rd !== 2'd1) begin n_fail++; $display("FAIL ld_rd: got %0d want 1", out_rd); end
        $display("op ld r1=0011 result=%b rd=%0d", out_result, out_rd);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL ld_op_count: got %0d want 1", op_count); end
    endtask

    task automatic test_add_carry();
        exec_op(mk(1'b1, 3'b000, 2'd0, 2'b11, 2'b11), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        exec_op(mk(1'b1, 3'b000, 2'd1, 2'b00, 2'b01), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        exec_op(mk(1'b0, 3'b000, 2'd2, 2'd0, 2'd1), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        n_checks++; if ({r_a, r_b} !== 8'b1111_0001) begin n_fail++; $display("FAIL add_operands: got %b want 11110001", {r_a, r_b}); end
        n_checks++; if (r_lat !== 1) begin n_fail++; $display("FAIL add_latency: got %0d want 1", r_lat); end
        n_checks++; if ({r_res, r_c, r_z} !== 6'b0000_11) begin n_fail++; $display("FAIL add_result: got %b want 000011", {r_res, r_c, r_z}); end
        n_checks++; if (r_rd !== 2'd2) begin n_fail++; $display("FAIL add_rd: got %0d want 2", r_rd); end
        exec_op(mk(1'b0, 3'b011, 2'd3, 2'd2, 2'd1), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        n_checks++; if ({r_res, r_c, r_z} !== 6'b0001_00) begin n_fail++; $display("FAIL or_writeback: got %b want 000100", {r_res, r_c, r_z}); end
        n_checks++; if (r_rd !== 2'd3) begin n_fail++; $display("FAIL or_rd: got %0d want 3", r_rd); end
    endtask

    task automatic test_backpressure();
        logic [7:0] cnt_before;
        exec_op(mk(1'b1, 3'b000, 2'd0, 2'b10, 2'b10), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        exec_op(mk(1'b1, 3'b000, 2'd1, 2'b01, 2'b01), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        cnt_before = op_count;
        // sub r2 = r0 - r1, then stall the output for 5 cycles.
        @(negedge clk);
        in_instr = mk(1'b0, 3'b001, 2'd2, 2'd0, 2'd1);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 5; i++) begin
            // Offer a load to r3 mid-stall; it must not be consumed.
            if (i == 2) begin
                in_instr = mk(1'b1, 3'b000, 2'd3, 2'b11, 2'b11);
                in_valid = 1'b1;
            end else begin
                in_valid = 1'b0;
            end
            @(negedge clk);
            n_checks++; if ({out_valid, in_ready, out_result, out_carry} !== 7'b1_0_0101_0) begin n_fail++;
                $display("FAIL bp_hold_%0d: got valid/ready/result/carry %b want 1001010", i, {out_valid, in_ready, out_result, out_carry}); end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        $display("op sub stalled result=%b count=%0d", out_result, op_count);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        n_checks++; if (op_count !== 8'(cnt_before + 8'd1)) begin n_fail++; $display("FAIL bp_op_count: got %0d want %0d", op_count, cnt_before + 8'd1); end
        n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL bp_release: got valid/ready %b want 01", {out_valid, in_ready}); end
        // r3 still holds 0001 from the add test; the ignored load must not have changed it.
        exec_op(mk(1'b0, 3'b011, 2'd2, 2'd3, 2'd3), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        n_checks++; if (r_res !== 4'b0001) begin n_fail++; $display("FAIL bp_not_consumed: got r3 %b want 0001", r_res); end
    endtask

    task automatic test_shifts();
        exec_op(mk(1'b1, 3'b000, 2'd0, 2'b11, 2'b00), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        exec_op(mk(1'b0, 3'b110, 2'd1, 2'd0, 2'd0), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        n_checks++; if (r_ctl !== 3'b110) begin n_fail++; $display("FAIL shl_ctrl: got %b want 110", r_ctl); end
        n_checks++; if ({r_res, r_c, r_z} !== 6'b1000_10) begin n_fail++; $display("FAIL shl_result: got %b want 100010", {r_res, r_c, r_z}); end
        exec_op(mk(1'b0, 3'b111, 2'd1, 2'd0, 2'd0), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        n_checks++; if (r_ctl !== 3'b111) begin n_fail++; $display("FAIL shr_ctrl: got %b want 111", r_ctl); end
        n_checks++; if ({r_res, r_c, r_z} !== 6'b0110_00) begin n_fail++; $display("FAIL shr_result: got %b want 011000", {r_res, r_c, r_z}); end
    endtask

    task automatic test_reset_mid_op();
        // Reset during OUT: out_valid must drop before the next clock edge.
        exec_op(mk(1'b1, 3'b000, 2'd1, 2'b01, 2'b01), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        @(negedge clk);
        in_instr = mk(1'b1, 3'b000, 2'd3, 2'b01, 2'b01);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_out_async: got valid/ready %b want 01", {out_valid, in_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        // Reset during EXEC of ld r2 = 1010.
        @(negedge clk);
        in_instr = mk(1'b1, 3'b000, 2'd2, 2'b10, 2'b10);
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        n_checks++; if ({out_valid, in_ready} !== 2'b01) begin n_fail++; $display("FAIL rst_exec_state: got valid/ready %b want 01", {out_valid, in_ready}); end
        @(negedge clk);
        rst_n = 1'b1;
        exec_op(mk(1'b0, 3'b011, 2'd3, 2'd2, 2'd2), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        n_checks++; if ({r_res, r_z} !== 5'b0000_1) begin n_fail++; $display("FAIL rst_no_writeback: got result/zero %b want 00001", {r_res, r_z}); end
        n_checks++; if (op_count !== 8'd1) begin n_fail++; $display("FAIL rst_op_count: got %0d want 1", op_count); end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int i = 0; i < 5; i++)
            exec_op(mk(1'b1, 3'b000, 2'(i), 2'b00, 2'(i)), r_res, r_c, r_z, r_rd, r_a, r_b, r_ctl, r_lat);
        n_checks++; if (w_op_count !== 2'd1) begin n_fail++; $display("FAIL wrap_op_count_w2: got %0d want 1", w_op_count); end
        n_checks++; if (op_count !== 8'd5) begin n_fail++; $display("FAIL wrap_op_count_w8: got %0d want 5", op_count); end
    endtask

    initial begin
        test_reset();
        test_add_carry();
        test_backpressure();
        test_shifts();
        test_reset_mid_op();
        test_counter_wrap();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Watchdog so that the run always ends, even if the DUT stops responding.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
